// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable instruction memory, PC, IF/ID register and IDLE/RUN/HALTED run control.
// Define FETCH_PERF_CNT_EN to build the saturating fetch_count performance counter.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   pc,
  output logic [31:0]   if_id_instr,
  output logic [5:0]    if_id_opcode,
  output logic [31:0]   if_id_pc4,
  output logic          if_id_valid,
  output logic          running,
  output logic          halted,
  output logic          fetch_err,
  output logic [31:0]   fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic        in_range, is_halt;
  logic [31:0] pc_nxt, instr_nxt, pc4_nxt;
  logic        valid_nxt, err_nxt;

  // The program can only be rewritten while the pipeline is not fetching.
  always_ff @(posedge clk) begin
    if (load_en && state != RUN)
      imem[load_addr] <= load_data;
  end

  assign in_range   = (pc[31:AW+2] == '0);
  assign fetch_word = in_range ? imem[pc[AW+1:2]] : 32'h0;
  assign is_halt    = (fetch_word == 32'hFFFF_FFFF);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    pc4_nxt   = if_id_pc4;
    valid_nxt = if_id_valid;
    err_nxt   = fetch_err;
    case (state)
      RUN: begin
        if (!in_range)
          err_nxt = 1'b1;
        if (redirect) begin
          pc_nxt    = {redirect_pc[31:2], 2'b00};
          instr_nxt = '0;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
          if (redirect_pc[1:0] != 2'b00)
            err_nxt = 1'b1;
        end else if (!stall) begin
          if (is_halt) begin
            instr_nxt = '0;
            pc4_nxt   = '0;
            valid_nxt = 1'b0;
            state_nxt = HALTED;
          end else begin
            instr_nxt = fetch_word;
            pc4_nxt   = pc + 32'd4;
            valid_nxt = 1'b1;
            pc_nxt    = pc + 32'd4;
          end
        end
      end
      default: begin
        instr_nxt = '0;
        pc4_nxt   = '0;
        valid_nxt = 1'b0;
        if (start) begin
          pc_nxt    = RESET_PC;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
      fetch_err   <= err_nxt;
    end
  end

  assign if_id_opcode = if_id_instr[31:26];
  assign running      = (state == RUN);
  assign halted       = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic issue;
  assign issue = (state == RUN) && !redirect && !stall && !is_halt;

  // Counts real instructions entering IF/ID; restarts with each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (state != RUN && start)
      fetch_count <= '0;
    else if (issue && fetch_count != 32'hFFFF_FFFF)
      fetch_count <= fetch_count + 32'd1;
  end
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program/stall/redirect/error/reset scenarios plus
// randomized episodes compared every cycle against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int          DEPTH = 64;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, load_en = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0, redirect_pc = '0;
  logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
  logic [5:0]  if_id_opcode;
  logic        if_id_valid, running, halted, fetch_err;

  int nPass = 0;
  int nTotal = 0;
  bit chkEn = 1'b0;

  // Behavioural model state, initialised to the reset values.
  logic [31:0] mMem [DEPTH];
  logic [31:0] mPc = RPC, mInstr = '0, mPc4 = '0, mCnt = '0;
  bit          mValid = 1'b0, mRun = 1'b0, mHalt = 1'b0, mErr = 1'b0;
  logic [31:0] prog [DEPTH];

  instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .running(running), .halted(halted), .fetch_err(fetch_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Model: one step per rising edge, derived from the fetch rules with plain arithmetic.
  always @(posedge clk or negedge rst_n) begin : modelStep
    logic [31:0] wordIdx;
    logic [31:0] fw;
    bit          inRange;
    if (!rst_n) begin
      mPc = RPC; mInstr = '0; mPc4 = '0; mValid = 1'b0;
      mRun = 1'b0; mHalt = 1'b0; mErr = 1'b0; mCnt = '0;
    end else if (mRun) begin
      wordIdx = mPc / 4;
      inRange = wordIdx < 32'(DEPTH);
      fw = inRange ? mMem[wordIdx[5:0]] : 32'h0;
      if (!inRange) mErr = 1'b1;
      if (redirect) begin
        if (redirect_pc % 4 != 0) mErr = 1'b1;
        mPc = redirect_pc - (redirect_pc % 4);
        mInstr = '0; mPc4 = '0; mValid = 1'b0;
      end else if (stall) begin
        mPc = mPc;
      end else if (fw == 32'hFFFF_FFFF) begin
        mInstr = '0; mPc4 = '0; mValid = 1'b0;
        mRun = 1'b0; mHalt = 1'b1;
      end else begin
        mInstr = fw; mPc4 = mPc + 4; mValid = 1'b1; mPc = mPc + 4;
        if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      end
    end else begin
      mInstr = '0; mPc4 = '0; mValid = 1'b0;
      if (load_en) mMem[load_addr] = load_data;
      if (start) begin
        mPc = RPC; mRun = 1'b1; mHalt = 1'b0; mCnt = '0;
      end
    end
  end

  function automatic logic [31:0] expCount();
`ifdef FETCH_PERF_CNT_EN
    return mCnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("pc", pc, mPc);
      checkOutput("if_id_instr", if_id_instr, mInstr);
      checkOutput("if_id_opcode", 32'(if_id_opcode), 32'(mInstr[31:26]));
      checkOutput("if_id_pc4", if_id_pc4, mPc4);
      checkOutput("if_id_valid", 32'(if_id_valid), 32'(mValid));
      checkOutput("running", 32'(running), 32'(mRun));
      checkOutput("halted", 32'(halted), 32'(mHalt));
      checkOutput("fetch_err", 32'(fetch_err), 32'(mErr));
      checkOutput("fetch_count", fetch_count, expCount());
    end
  end

  // Drives the inputs consumed by the next rising edge; on return the outputs reflect all earlier edges.
  task automatic applyStimulus(input bit st, input bit le, input logic [5:0] la, input logic [31:0] ld,
                               input bit stl, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    #1;
    start = st; load_en = le; load_addr = la; load_data = ld;
    stall = stl; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chkEn = 1'b1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
    checkOutput("rst_running", 32'(running), 32'h0);
    checkOutput("rst_count", fetch_count, 32'h0);
    rst_n = 1'b1;

    prog[0] = 32'h2008_0005; prog[1] = 32'h8D09_0000;
    prog[2] = 32'hAD09_0004; prog[3] = 32'hFFFF_FFFF;
    for (int i = 4; i < DEPTH; i++) prog[i] = 32'h0100_0000 + 32'(i);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 6'(i), prog[i], 1'b0, 1'b0, 32'h0);

    // Straight-line program ending on the halt word.
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    checkOutput("start_running", 32'(running), 32'h1);
    checkOutput("start_pc", pc, 32'h0);
    idle();
    checkOutput("sl_instr0", if_id_instr, 32'h2008_0005);
    checkOutput("sl_pc4_0", if_id_pc4, 32'h4);
    checkOutput("sl_opc0", 32'(if_id_opcode), 32'h08);
    idle();
    checkOutput("sl_instr1", if_id_instr, 32'h8D09_0000);
    checkOutput("sl_pc4_1", if_id_pc4, 32'h8);
    checkOutput("sl_opc1", 32'(if_id_opcode), 32'h23);
    idle();
    checkOutput("sl_instr2", if_id_instr, 32'hAD09_0004);
    checkOutput("sl_pc4_2", if_id_pc4, 32'hC);
    checkOutput("sl_opc2", 32'(if_id_opcode), 32'h2B);
    idle();
    checkOutput("sl_halted", 32'(halted), 32'h1);
    checkOutput("sl_halt_pc", pc, 32'hC);
    checkOutput("sl_halt_valid", 32'(if_id_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("sl_count", fetch_count, 32'h3);
`endif

    // Two-cycle stall while IF/ID holds the word fetched from pc=4.
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st_pre_instr", if_id_instr, 32'h8D09_0000);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st_hold1_instr", if_id_instr, 32'h8D09_0000);
    checkOutput("st_hold1_pc", pc, 32'h8);
    idle();
    checkOutput("st_hold2_instr", if_id_instr, 32'h8D09_0000);
    checkOutput("st_hold2_pc", pc, 32'h8);
    checkOutput("st_hold2_valid", 32'(if_id_valid), 32'h1);

    // Redirect with a simultaneous stall, also squashing the pending halt fetch at pc=12.
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 32'h10);
    checkOutput("st_after_instr", if_id_instr, 32'hAD09_0004);
    checkOutput("st_after_pc4", if_id_pc4, 32'hC);
    idle();
    checkOutput("rd_pc", pc, 32'h10);
    checkOutput("rd_bubble", 32'(if_id_valid), 32'h0);
    checkOutput("rd_not_halted", 32'(halted), 32'h0);

    // Misaligned and out-of-range redirects.
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h11);
    checkOutput("rd_target_instr", if_id_instr, 32'h0100_0004);
    checkOutput("rd_target_pc4", if_id_pc4, 32'h14);
    checkOutput("rd_err_clear", 32'(fetch_err), 32'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h100);
    checkOutput("mis_pc", pc, 32'h10);
    checkOutput("mis_err", 32'(fetch_err), 32'h1);
    idle();
    checkOutput("oor_pc", pc, 32'h100);
    applyStimulus(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    checkOutput("oor_nop", if_id_instr, 32'h0);
    checkOutput("oor_valid", 32'(if_id_valid), 32'h1);
    checkOutput("oor_pc4", if_id_pc4, 32'h104);
    checkOutput("oor_err", 32'(fetch_err), 32'h1);

    // A load while running must leave imem[5] untouched.
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h14);
    idle();
    idle();
    checkOutput("gate_instr", if_id_instr, 32'h0100_0005);
    checkOutput("gate_pc4", if_id_pc4, 32'h18);

    // Asynchronous reset mid-run, then the program must still be present.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_pc", pc, 32'h0);
    checkOutput("arst_instr", if_id_instr, 32'h0);
    checkOutput("arst_running", 32'(running), 32'h0);
    checkOutput("arst_err", 32'(fetch_err), 32'h0);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    checkOutput("survive_instr", if_id_instr, 32'h2008_0005);

    // Randomized episodes: reload parts of memory, run with random stalls, redirects and loads.
    for (int ep = 0; ep < 25; ep++) begin
      int nLoads;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      nLoads = $urandom_range(8, 40);
      for (int k = 0; k < nLoads; k++) begin
        logic [31:0] w;
        w = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
        applyStimulus(1'b0, 1'b1, 6'($urandom_range(0, DEPTH - 1)), w, 1'b0, 1'b0, 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 60; c++) begin
        logic [31:0] rpc;
        rpc = 32'($urandom_range(0, 70)) * 4;
        if ($urandom_range(0, 9) == 0) rpc = rpc + 32'($urandom_range(1, 3));
        applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                      6'($urandom_range(0, DEPTH - 1)), $urandom,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rpc);
      end
    end

    idle();
    idle();
    chkEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the pipelined MIPS datapath. It holds a loadable instruction memory, a program counter and the IF/ID pipeline register, and sources the 6-bit opcode consumed by the decode-stage control unit. A small run-control FSM covers three phases: program load, fetching, and stopping on a halt word. Stall and redirect inputs come from the hazard unit and the branch/jump resolution logic.

## Interface
- IMEM_DEPTH, 64: instruction memory size in 32-bit words; a power of two. AW = log2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000: PC value after reset and after each start; must be word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins fetching from RESET_PC.
- load_en  in  1  instruction memory write strobe.
- load_addr  in  AW  word address for the write.
- load_data  in  32  instruction word to write.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect  in  1  taken branch or jump: flush IF/ID and load the PC.
- redirect_pc  in  32  redirect target.
- pc  out  32  current fetch address.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_opcode  out  6  if_id_instr[31:26], to the control unit.
- if_id_pc4  out  32  fetch address + 4 of the instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- running  out  1  FSM is in RUN.
- halted  out  1  FSM is in HALTED.
- fetch_err  out  1  sticky error flag.
- fetch_count  out  32  performance counter; see Configuration.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- FSM transitions:
  - IDLE/HALTED, start=1: pc <= RESET_PC, next state RUN.
  - RUN, halt word fetched: next state HALTED.
  - start is ignored while in RUN.
- Instruction memory:
  - Written only when load_en=1 in IDLE or HALTED: imem[load_addr] <= load_data.
  - load_en is ignored in RUN.
  - Contents are not reset.
- Fetch word:
  - Read combinationally as imem[pc[AW+1:2]].
  - If pc[31:2] >= IMEM_DEPTH, the fetch word is forced to 32'h0 (NOP) and fetch_err is set.
- Per-edge priority in RUN: redirect > stall > halt > normal.
  - redirect: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (instr 0, pc4 0, valid 0). If redirect_pc[1:0] != 0, fetch_err is set. Redirect wins over a simultaneous stall.
  - stall: pc and IF/ID hold their values.
  - halt (fetch word == 32'hFFFF_FFFF): the halt word is not issued; IF/ID <= bubble; pc holds at the halt address; next state HALTED.
  - normal: IF/ID <= {fetch word, pc+4, valid 1}; pc <= pc+4. PC arithmetic is modulo 2^32.
- IDLE/HALTED without start: pc holds; IF/ID <= bubble every edge.
- fetch_err is cleared only by reset.

## Timing
- Reset values:
  - pc=RESET_PC.
  - if_id_instr=0, if_id_opcode=0, if_id_pc4=0, if_id_valid=0.
  - running=0, halted=0, fetch_err=0, fetch_count=0.
- Reset is asynchronous. Asserting it mid-run clears all state immediately; the instruction memory is untouched.
- Start sampled at edge T: running=1 after T with pc=RESET_PC. imem[RESET_PC] appears in IF/ID after edge T+1.
- Fetch-to-IF/ID latency is 1 cycle. Throughput is 1 instruction/cycle when there is no stall.
- Redirect sampled at edge T: a bubble is in IF/ID after T. The target instruction is in IF/ID after T+1, a one-bubble penalty.
- A stall held for N edges freezes IF/ID for N cycles. The instruction held in IF/ID stays valid and is not duplicated downstream.
- halted=1 after the edge that sampled the halt word. A redirect on that same edge squashes the halt.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - fetch_count increments on every edge that loads IF/ID with valid=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset and by start.
- FETCH_PERF_CNT_EN undefined: fetch_count is tied to 32'h0 and no counter logic is built.

## Test plan
- Straight line: load words 0..3 = 0x20080005, 0x8D090000, 0xAD090004, 0xFFFFFFFF; pulse start.
  - IF/ID shows the three words on consecutive cycles with if_id_pc4 = 4, 8, 12 and opcodes 0x08, 0x23, 0x2B.
  - Then halted=1 with pc=12.
  - fetch_count=3 when the macro is defined.
- Stall: assert stall for 2 cycles while IF/ID holds the word at pc=4.
  - IF/ID and pc are frozen for both cycles.
  - The word from pc=8 follows one cycle after stall drops.
- Redirect with simultaneous stall: redirect_pc=0x10, stall=1.
  - Next cycle: pc=0x10 and if_id_valid=0.
  - Following cycle: IF/ID = imem[4] with if_id_pc4=0x14.
- Errors: redirect_pc=0x11 gives pc=0x10 and fetch_err=1. Redirect to 0x100 with IMEM_DEPTH=64 issues a NOP; fetch_err stays 1.
- Load gating and reset: load_en during RUN leaves memory unchanged. Deasserting rst_n mid-run clears pc, IF/ID and the FSM asynchronously. Loaded program words survive reset.
